// File: rtl/tiger_alu_seq_pkg.sv
// rtl/tiger_alu_seq_pkg.sv - Tiger ALU op codes, FSM states and decode helpers
package tiger_alu_seq_pkg;

    localparam logic [4:0] ALU_UNSIGNED = 5'h10;

    localparam logic [4:0] ALU_ADD  = 5'h00;
    localparam logic [4:0] ALU_SUB  = 5'h01;
    localparam logic [4:0] ALU_AND  = 5'h02;
    localparam logic [4:0] ALU_OR   = 5'h03;
    localparam logic [4:0] ALU_XOR  = 5'h04;
    localparam logic [4:0] ALU_NOR  = 5'h05;
    localparam logic [4:0] ALU_SLT  = 5'h06;
    localparam logic [4:0] ALU_LUI  = 5'h07;
    localparam logic [4:0] ALU_SLL  = 5'h08;
    localparam logic [4:0] ALU_SRL  = 5'h09;
    localparam logic [4:0] ALU_SRA  = 5'h0A;
    localparam logic [4:0] ALU_MULT = 5'h0B;
    localparam logic [4:0] ALU_DIV  = 5'h0C;
    localparam logic [4:0] ALU_MFHI = 5'h0D;
    localparam logic [4:0] ALU_MFLO = 5'h0E;

    localparam logic [4:0] ALU_ADDU  = ALU_ADD  | ALU_UNSIGNED;
    localparam logic [4:0] ALU_SUBU  = ALU_SUB  | ALU_UNSIGNED;
    localparam logic [4:0] ALU_SLTU  = ALU_SLT  | ALU_UNSIGNED;
    localparam logic [4:0] ALU_MULTU = ALU_MULT | ALU_UNSIGNED;
    localparam logic [4:0] ALU_DIVU  = ALU_DIV  | ALU_UNSIGNED;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_HOLD
    } alu_state_t;

    function automatic logic is_muldiv(input logic [4:0] code);
        return (code == ALU_MULT) || (code == ALU_MULTU) ||
               (code == ALU_DIV)  || (code == ALU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] code);
        return (code == ALU_DIV) || (code == ALU_DIVU);
    endfunction

endpackage

// File: rtl/tiger_muldiv_iter.sv
// rtl/tiger_muldiv_iter.sv - iterative radix-2 multiply / restoring divide producing HI/LO
module tiger_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    // acc: product high half / partial remainder; sh: multiplier / dividend bits
    logic [WIDTH-1:0] acc, sh, opnd;
    logic [CW-1:0]    cnt;
    logic             run, div_r, neg_q, neg_r, b_zero;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_sum, div_sh, div_diff;
    logic [WIDTH-1:0] acc_nxt, sh_nxt, quo, rem;
    logic [2*WIDTH-1:0] prod;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
    assign done  = run && (cnt == CW'(WIDTH - 1));

    always_comb begin
        add_sum  = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : '0);
        div_sh   = {acc, sh[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd};
        if (div_r) begin
            // top bit of the difference set means a borrow: restore
            if (!div_diff[WIDTH]) begin
                acc_nxt = div_diff[WIDTH-1:0];
                sh_nxt  = {sh[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = div_sh[WIDTH-1:0];
                sh_nxt  = {sh[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = add_sum[WIDTH:1];
            sh_nxt  = {add_sum[0], sh[WIDTH-1:1]};
        end
        prod = neg_q ? -{acc_nxt, sh_nxt} : {acc_nxt, sh_nxt};
        quo  = b_zero ? '1 : (neg_q ? -sh_nxt : sh_nxt);
        rem  = neg_r ? -acc_nxt : acc_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            sh     <= '0;
            opnd   <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            div_r  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (start) begin
            acc    <= '0;
            sh     <= a_mag;
            opnd   <= b_mag;
            cnt    <= '0;
            run    <= 1'b1;
            div_r  <= is_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            b_zero <= (b == '0);
        end else if (run) begin
            acc <= acc_nxt;
            sh  <= sh_nxt;
            cnt <= cnt + 1'b1;
            if (done) begin
                run <= 1'b0;
                if (div_r) begin
                    hi <= rem;
                    lo <= quo;
                end else begin
                    hi <= prod[2*WIDTH-1:WIDTH];
                    lo <= prod[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/tiger_alu_seq.sv
// rtl/tiger_alu_seq.sv - handshaked Tiger execute ALU with registered result and HI/LO mul/div
module tiger_alu_seq
    import tiger_alu_seq_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluout,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);
    alu_state_t       state, state_nxt;
    logic             accept, md_op, md_start, md_done, out_valid_r;
    logic [WIDTH-1:0] res, aluout_r;
    logic [SHW-1:0]   shamt;

    assign md_op     = is_muldiv(alucontrol);
    assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign md_start  = accept && md_op;
    assign busy      = (state == ST_MUL) || (state == ST_DIV);
    assign out_valid = out_valid_r || (state == ST_HOLD);
    assign aluout    = (state == ST_HOLD) ? lo : aluout_r;
    assign shamt     = srca[SHW-1:0];

    tiger_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (md_start),
        .is_div    (is_div_op(alucontrol)),
        .is_signed (!alucontrol[4]),
        .a         (srca),
        .b         (srcb),
        .done      (md_done),
        .hi        (hi),
        .lo        (lo)
    );

    always_comb begin
        res = '0;
        case (alucontrol)
            ALU_ADD, ALU_ADDU: res = srca + srcb;
            ALU_SUB, ALU_SUBU: res = srca - srcb;
            ALU_AND:           res = srca & srcb;
            ALU_OR:            res = srca | srcb;
            ALU_XOR:           res = srca ^ srcb;
            ALU_NOR:           res = ~(srca | srcb);
            ALU_SLT:           res = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
            ALU_SLTU:          res = {{(WIDTH-1){1'b0}}, srca < srcb};
            ALU_LUI:           res = {srcb[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_SLL:           res = srcb << shamt;
            ALU_SRL:           res = srcb >> shamt;
            ALU_SRA:           res = $signed(srcb) >>> shamt;
            ALU_MFHI:          res = hi;
            ALU_MFLO:          res = lo;
            default:           res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (md_start) state_nxt = is_div_op(alucontrol) ? ST_DIV : ST_MUL;
            ST_MUL,
            ST_DIV:  if (md_done) state_nxt = ST_HOLD;
            ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // A same-edge accept overrides the clear so back-to-back ops stream at one per cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            aluout_r    <= '0;
        end else if (accept && !md_op) begin
            out_valid_r <= 1'b1;
            aluout_r    <= res;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule
